// File: rtl/wallace_mult16.sv
// wallace_mult16: unsigned 16x16 -> 32 Wallace-tree multiplier with a registered product.
// Define WALLACE_MULT16_IN_REG_EN to add an input register stage, which gives 2-cycle latency.
module wallace_mult16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out,
  output logic        out_valid
);

  // Row count at each reduction level: 3 rows -> 2 (FA), a leftover pair -> HA, a single row passes through.
  localparam int ROWS [0:6] = '{16, 11, 8, 6, 4, 3, 2};

  logic [15:0] tree_a;
  logic [15:0] tree_b;
  logic        tree_v;

`ifdef WALLACE_MULT16_IN_REG_EN
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        v_q, v_d;

  // Operands are only loaded on valid cycles, so X on idle inputs never enters the tree.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    v_d = in_valid;
    if (in_valid) begin
      a_d = a;
      b_d = b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= 16'd0;
      b_q <= 16'd0;
      v_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      v_q <= v_d;
    end
  end

  assign tree_a = a_q;
  assign tree_b = b_q;
  assign tree_v = v_q;
`else
  assign tree_a = a;
  assign tree_b = b;
  assign tree_v = in_valid;
`endif

  logic [31:0] lvl [0:6][0:15];

  always_comb begin
    for (int lv = 0; lv < 7; lv++) begin
      for (int r = 0; r < 16; r++) begin
        lvl[lv][r] = 32'd0;
      end
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        lvl[0][i][i+j] = tree_a[j] & tree_b[i];
      end
    end

    // Carry-save reduction. Carries move up one bit position; anything shifted past bit 31 is zero
    // because the full product fits in 32 bits.
    for (int lv = 0; lv < 6; lv++) begin
      for (int g = 0; g < 5; g++) begin
        if (g < ROWS[lv] / 3) begin
          lvl[lv+1][2*g]   = lvl[lv][3*g] ^ lvl[lv][3*g+1] ^ lvl[lv][3*g+2];
          lvl[lv+1][2*g+1] = ((lvl[lv][3*g] & lvl[lv][3*g+1]) |
                              (lvl[lv][3*g] & lvl[lv][3*g+2]) |
                              (lvl[lv][3*g+1] & lvl[lv][3*g+2])) << 1;
        end
      end
      case (ROWS[lv] % 3)
        1: begin
          lvl[lv+1][2*(ROWS[lv]/3)] = lvl[lv][3*(ROWS[lv]/3)];
        end
        2: begin
          lvl[lv+1][2*(ROWS[lv]/3)]   = lvl[lv][3*(ROWS[lv]/3)] ^ lvl[lv][3*(ROWS[lv]/3)+1];
          lvl[lv+1][2*(ROWS[lv]/3)+1] = (lvl[lv][3*(ROWS[lv]/3)] & lvl[lv][3*(ROWS[lv]/3)+1]) << 1;
        end
        default: ;
      endcase
    end
  end

  logic [31:0] prod;
  logic        cpa_c;

  always_comb begin
    prod  = 32'd0;
    cpa_c = 1'b0;
    for (int k = 0; k < 32; k++) begin
      prod[k] = lvl[6][0][k] ^ lvl[6][1][k] ^ cpa_c;
      cpa_c   = (lvl[6][0][k] & lvl[6][1][k]) | (cpa_c & (lvl[6][0][k] ^ lvl[6][1][k]));
    end
  end

  logic [31:0] out_q, out_d;
  logic        out_valid_q, out_valid_d;

  always_comb begin
    out_d       = out_q;
    out_valid_d = tree_v;
    if (tree_v) begin
      out_d = prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wallace_mult16.sv
// tb_wallace_mult16: directed and random checks of wallace_mult16 with a latency-aware expectation pipe.
module tb_wallace_mult16;

`ifdef WALLACE_MULT16_IN_REG_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] out;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  logic        pv [0:1];
  logic [31:0] po [0:1];
  logic [31:0] held;

  wallace_mult16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_pipe();
    for (int k = 0; k < 2; k++) begin
      pv[k] = 1'b0;
      po[k] = 32'd0;
    end
    held = 32'd0;
  endtask

  // One clock: check what the DUT shows now against the product issued L cycles ago, then drive.
  task automatic cyc(input string tag, input logic v, input logic [15:0] av,
                     input logic [15:0] bv, input logic [31:0] ex);
    @(negedge clk);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, pv[L-1]});
    if (pv[L-1]) held = po[L-1];
    chk({tag, ".out"}, out, held);
    for (int k = L - 1; k > 0; k--) begin
      pv[k] = pv[k-1];
      po[k] = po[k-1];
    end
    pv[0] = v;
    po[0] = ex;
    in_valid = v;
    a = av;
    b = bv;
    $display("txn %s v=%0b a=%h b=%h expect=%0d", tag, v, av, bv, ex);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rv;

    clear_pipe();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'd123;
    b        = 16'd456;
    #1;
    chk("rst0.out", out, 32'd0);
    chk("rst0.valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.out", out, 32'd0);
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Corners, each isolated with X on idle operands.
    cyc("zero", 1'b1, 16'd0, 16'd0, 32'd0);
    for (int i = 0; i < L + 1; i++) cyc("idle", 1'b0, 16'hxxxx, 16'hxxxx, 32'd0);
    cyc("one", 1'b1, 16'd1, 16'd1, 32'd1);
    for (int i = 0; i < L + 1; i++) cyc("idle", 1'b0, 16'hxxxx, 16'hxxxx, 32'd0);
    cyc("max", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    for (int i = 0; i < L + 1; i++) cyc("idle", 1'b0, 16'hxxxx, 16'hxxxx, 32'd0);

    // Hold: the all-ones operands on invalid cycles must not disturb the last product.
    cyc("hold_v", 1'b1, 16'd123, 16'd456, 32'd56088);
    for (int i = 0; i < L + 3; i++) cyc("hold", 1'b0, 16'hFFFF, 16'hFFFF, 32'd0);

    // Streaming back-to-back.
    cyc("s123x456", 1'b1, 16'd123, 16'd456, 32'd56088);
    cyc("s255x255", 1'b1, 16'd255, 16'd255, 32'd65025);
    cyc("s32767x2", 1'b1, 16'd32767, 16'd2, 32'd65534);
    cyc("s1024x1024", 1'b1, 16'd1024, 16'd1024, 32'd1048576);
    cyc("s30000x3", 1'b1, 16'd30000, 16'd3, 32'd90000);
    cyc("s500x1000", 1'b1, 16'd500, 16'd1000, 32'd500000);
    cyc("smax", 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    cyc("szero", 1'b1, 16'd0, 16'hFFFF, 32'd0);
    for (int i = 0; i < L + 1; i++) cyc("idle", 1'b0, 16'd0, 16'd0, 32'd0);

    // Random traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rv = ($urandom_range(0, 3) != 0);
      cyc("rand", rv, ra, rb, {16'd0, ra} * {16'd0, rb});
    end
    for (int i = 0; i < L + 1; i++) cyc("idle", 1'b0, 16'd0, 16'd0, 32'd0);

    // Mid-stream asynchronous reset with products in flight.
    cyc("pre_rst0", 1'b1, 16'd500, 16'd1000, 32'd500000);
    cyc("pre_rst1", 1'b1, 16'd30000, 16'd3, 32'd90000);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out", out, 32'd0);
    chk("async_rst.valid", {31'd0, out_valid}, 32'd0);
    clear_pipe();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < L + 2; i++) cyc("post_rst", 1'b0, 16'hFFFF, 16'hFFFF, 32'd0);
    cyc("recover", 1'b1, 16'd255, 16'd255, 32'd65025);
    for (int i = 0; i < L + 1; i++) cyc("idle", 1'b0, 16'd0, 16'd0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
